// File: rtl/jam_cost_server_pkg.sv
// rtl/jam_cost_server_pkg.sv - shared constants and state encoding for the JAM cost server
package jam_cost_server_pkg;

   localparam int DEF_COST_W   = 7;
   localparam int DEF_HOLD_CYC = 2;
   localparam int IDX_W        = 3;
   localparam int ADDR_W       = 2 * IDX_W;
   localparam int DEPTH        = 1 << ADDR_W;
   localparam int HCNT_W       = 8;
   localparam int ACC_W        = 19;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/jam_cost_server_table.sv
// rtl/jam_cost_server_table.sv - 64-entry cost table, one write port, one registered read port
module jam_cost_table
   import jam_cost_server_pkg::*;
#(
   parameter int COST_W = DEF_COST_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [COST_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [COST_W-1:0] o_rdata
);

   logic [COST_W-1:0] r_mem [DEPTH];
   logic [COST_W-1:0] r_rdata;

   // Table storage: cleared by reset, written one entry per accepted load beat
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read: answers the address of the previous cycle, zero when not enabled
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end else begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - JAM cost table server; optional JAM_ACCESS_CNT_EN adds acc_cnt
module jam_cost_server
   import jam_cost_server_pkg::*;
#(
   parameter int COST_W   = DEF_COST_W,
   parameter int HOLD_CYC = DEF_HOLD_CYC
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [COST_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_err,
   input  logic              restart,
   input  logic              reload,
   input  logic [IDX_W-1:0]  W,
   input  logic [IDX_W-1:0]  J,
   output logic [COST_W-1:0] Cost,
   output logic              jam_rst,
   input  logic              Valid,
   input  logic [9:0]        MinCost,
   input  logic [3:0]        MatchCount,
   output logic              res_valid,
   output logic [9:0]        res_min_cost,
   output logic [3:0]        res_match_cnt,
   output logic              busy
`ifdef JAM_ACCESS_CNT_EN
   ,
   output logic [ACC_W-1:0]  acc_cnt
`endif
);

   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [HCNT_W-1:0]   r_hold_cnt;
   logic                r_ld_ready;
   logic                r_ld_err;
   logic                r_jam_rst;
   logic                r_busy;
   logic                r_res_valid;
   logic [9:0]          r_res_min_cost;
   logic [3:0]          r_res_match_cnt;

   logic                w_beat_acc;
   logic                w_beat_last;
   logic                w_beat_bad;
   logic                w_restart;
   logic                w_reload;
   logic                w_enter_hold;
   logic                w_hold_done;
   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_raddr;
   logic [COST_W-1:0]   w_rdata;

   // ld_ready is high exactly while in LOAD, so it doubles as the accept qualifier
   assign w_beat_acc   = ld_valid & r_ld_ready;
   assign w_beat_last  = (r_idx == LAST_IDX);
   assign w_beat_bad   = w_beat_acc & (ld_last != w_beat_last);
   assign w_reload     = (r_state == ST_DONE) & reload;
   assign w_restart    = (r_state == ST_DONE) & restart & ~reload;
   assign w_enter_hold = (w_beat_acc & w_beat_last) | w_restart;
   assign w_hold_done  = (r_state == ST_HOLD) & (r_hold_cnt == HOLD_LAST);
   assign w_rd_en      = (r_state == ST_RUN);
   assign w_raddr      = {W, J};

   jam_cost_table #(
      .COST_W (COST_W)
   ) u_table (
      .CLK     (CLK),
      .RST     (RST),
      .i_we    (w_beat_acc),
      .i_waddr (r_idx),
      .i_wdata (ld_data),
      .i_re    (w_rd_en),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Sequencer: load the table, hold the engine in reset, run it, then park with the result
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state         <= ST_LOAD;
         r_idx           <= '0;
         r_hold_cnt      <= '0;
         r_ld_ready      <= 1'b1;
         r_ld_err        <= 1'b0;
         r_jam_rst       <= 1'b1;
         r_busy          <= 1'b0;
         r_res_valid     <= 1'b0;
         r_res_min_cost  <= '0;
         r_res_match_cnt <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_beat_acc) begin
                  r_idx <= r_idx + 1'b1;
                  if (w_beat_bad) begin
                     r_ld_err <= 1'b1;
                  end
                  if (w_beat_last) begin
                     r_state     <= ST_HOLD;
                     r_ld_ready  <= 1'b0;
                     r_hold_cnt  <= '0;
                     r_busy      <= 1'b1;
                     r_res_valid <= 1'b0;
                  end
               end
            end
            ST_HOLD: begin
               if (w_hold_done) begin
                  r_state   <= ST_RUN;
                  r_jam_rst <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (Valid) begin
                  r_state         <= ST_DONE;
                  r_jam_rst       <= 1'b1;
                  r_busy          <= 1'b0;
                  r_res_valid     <= 1'b1;
                  r_res_min_cost  <= MinCost;
                  r_res_match_cnt <= MatchCount;
               end
            end
            ST_DONE: begin
               if (w_reload) begin
                  r_state     <= ST_LOAD;
                  r_idx       <= '0;
                  r_ld_err    <= 1'b0;
                  r_ld_ready  <= 1'b1;
                  r_res_valid <= 1'b0;
               end else if (w_restart) begin
                  r_state     <= ST_HOLD;
                  r_hold_cnt  <= '0;
                  r_busy      <= 1'b1;
                  r_res_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_LOAD;
            end
         endcase
      end
   end

`ifdef JAM_ACCESS_CNT_EN
   logic [ACC_W-1:0] r_acc_cnt;

   // Query-cycle counter: restarts with each engine run, saturates instead of wrapping
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_acc_cnt <= '0;
      end else if (w_enter_hold) begin
         r_acc_cnt <= '0;
      end else if ((r_state == ST_RUN) && (r_acc_cnt != '1)) begin
         r_acc_cnt <= r_acc_cnt + 1'b1;
      end
   end

   assign acc_cnt = r_acc_cnt;
`endif

   assign ld_ready      = r_ld_ready;
   assign ld_err        = r_ld_err;
   assign jam_rst       = r_jam_rst;
   assign busy          = r_busy;
   assign res_valid     = r_res_valid;
   assign res_min_cost  = r_res_min_cost;
   assign res_match_cnt = r_res_match_cnt;
   assign Cost          = w_rdata;

endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - randomized self-checking bench for jam_cost_server
module tb_jam_cost_server;

   localparam int HOLD_CYC = 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ld_valid;
   logic       ld_ready;
   logic [6:0] ld_data;
   logic       ld_last;
   logic       ld_err;
   logic       restart;
   logic       reload;
   logic [2:0] W;
   logic [2:0] J;
   logic [6:0] Cost;
   logic       jam_rst;
   logic       Valid;
   logic [9:0] MinCost;
   logic [3:0] MatchCount;
   logic       res_valid;
   logic [9:0] res_min_cost;
   logic [3:0] res_match_cnt;
   logic       busy;
`ifdef JAM_ACCESS_CNT_EN
   logic [18:0] acc_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [6:0] exp_mem [64];
   bit         exp_err;
   logic [9:0] exp_min;
   logic [3:0] exp_cnt;

   jam_cost_server #(
      .COST_W   (7),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ld_valid      (ld_valid),
      .ld_ready      (ld_ready),
      .ld_data       (ld_data),
      .ld_last       (ld_last),
      .ld_err        (ld_err),
      .restart       (restart),
      .reload        (reload),
      .W             (W),
      .J             (J),
      .Cost          (Cost),
      .jam_rst       (jam_rst),
      .Valid         (Valid),
      .MinCost       (MinCost),
      .MatchCount    (MatchCount),
      .res_valid     (res_valid),
      .res_min_cost  (res_min_cost),
      .res_match_cnt (res_match_cnt),
      .busy          (busy)
`ifdef JAM_ACCESS_CNT_EN
      ,
      .acc_cnt       (acc_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ld_ready"}, ld_ready, 1);
      chk({tag, "_jam_rst"}, jam_rst, 1);
      chk({tag, "_cost"}, Cost, 0);
      chk({tag, "_ld_err"}, ld_err, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_min"}, res_min_cost, 0);
      chk({tag, "_res_cnt"}, res_match_cnt, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Streams n_beats row-major entries; bad_beat gets an inverted ld_last marker
   task automatic load_table(input int mode, input int bad_beat, input int n_beats);
      logic [6:0] d;
      logic       last;
      exp_err = 1'b0;
      for (int k = 0; k < n_beats; k++) begin
         int gaps = $urandom_range(0, 2);
         repeat (gaps) begin
            ld_valid = 1'b0;
            ld_data  = 7'($urandom);
            ld_last  = 1'($urandom);
            Valid    = 1'($urandom);
            step();
         end
         d        = (mode == 0) ? 7'(k % 100) : 7'($urandom);
         last     = (k == 63);
         if (k == bad_beat) last = ~last;
         ld_valid = 1'b1;
         ld_data  = d;
         ld_last  = last;
         Valid    = (k == 63) ? 1'b0 : 1'($urandom);
         exp_mem[k] = d;
         if (last != (k == 63)) exp_err = 1'b1;
         step();
         ld_valid = 1'b0;
         Valid    = 1'b0;
         if (k == bad_beat) chk("ld_err_set", ld_err, 1);
         if (k == 62) begin
            chk("ld_ready_beat62", ld_ready, 1);
            chk("busy_beat62", busy, 0);
         end
      end
      if (n_beats == 64) begin
         chk("ld_ready_after_load", ld_ready, 0);
         chk("busy_after_load", busy, 1);
         chk("jam_rst_after_load", jam_rst, 1);
         chk("ld_err_after_load", ld_err, 32'(exp_err));
         chk("res_valid_after_load", res_valid, 0);
      end
   endtask

   // Counts cycles until the engine is released from reset
   task automatic wait_release();
      int c = 0;
      while (jam_rst && c < 20) begin
         Valid = 1'($urandom);
         step();
         c++;
      end
      Valid = 1'b0;
      chk("hold_cycles", c, HOLD_CYC);
      chk("busy_in_run", busy, 1);
      chk("res_valid_in_run", res_valid, 0);
   endtask

   // n RUN cycles of random queries, the last one carrying the result strobe
   task automatic run_engine(input int n, input int first_q, input logic [9:0] mc,
                             input logic [3:0] mcnt);
      logic [5:0] q;
      logic [5:0] prev;
      q = (first_q >= 0) ? 6'(first_q) : 6'($urandom);
      W = q[5:3];
      J = q[2:0];
      prev = q;
      for (int i = 0; i < n - 1; i++) begin
         ld_valid = 1'($urandom);
         ld_data  = 7'($urandom);
         ld_last  = 1'($urandom);
         restart  = 1'($urandom);
         reload   = 1'($urandom);
         step();
         chk("cost", Cost, exp_mem[prev]);
         q = 6'($urandom);
         W = q[5:3];
         J = q[2:0];
         prev = q;
      end
      ld_valid   = 1'b0;
      restart    = 1'b0;
      reload     = 1'b0;
      Valid      = 1'b1;
      MinCost    = mc;
      MatchCount = mcnt;
      exp_min    = mc;
      exp_cnt    = mcnt;
      step();
      chk("cost_last", Cost, exp_mem[prev]);
      chk("res_valid_done", res_valid, 1);
      chk("res_min_done", res_min_cost, exp_min);
      chk("res_cnt_done", res_match_cnt, exp_cnt);
      chk("jam_rst_done", jam_rst, 1);
      chk("busy_done", busy, 0);
`ifdef JAM_ACCESS_CNT_EN
      chk("acc_cnt_done", acc_cnt, n);
`endif
      Valid      = 1'($urandom);
      MinCost    = 10'($urandom);
      MatchCount = 4'($urandom);
      step();
      Valid = 1'b0;
      chk("cost_in_done", Cost, 0);
      chk("res_min_held", res_min_cost, exp_min);
      chk("res_cnt_held", res_match_cnt, exp_cnt);
      chk("res_valid_held", res_valid, 1);
`ifdef JAM_ACCESS_CNT_EN
      chk("acc_cnt_held", acc_cnt, n);
`endif
   endtask

   task automatic do_reload();
      reload  = 1'b1;
      restart = 1'b1;
      step();
      reload  = 1'b0;
      restart = 1'b0;
      chk("reload_ld_ready", ld_ready, 1);
      chk("reload_busy", busy, 0);
      chk("reload_ld_err", ld_err, 0);
      chk("reload_res_valid", res_valid, 0);
      chk("reload_jam_rst", jam_rst, 1);
   endtask

   initial begin
      RST        = 1'b1;
      ld_valid   = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;
      restart    = 1'b0;
      reload     = 1'b0;
      W          = '0;
      J          = '0;
      Valid      = 1'b0;
      MinCost    = '0;
      MatchCount = '0;
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset_outputs("reset");
      RST = 1'b0;
      step();

      // Directed table, first query W=3,J=5, then restart on the same table
      load_table(0, -1, 64);
      wait_release();
      run_engine(50, 29, 10'd323, 4'd2);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_res_valid", res_valid, 0);
      chk("restart_busy", busy, 1);
      chk("restart_jam_rst", jam_rst, 1);
      chk("restart_res_min_kept", res_min_cost, 323);
      wait_release();
      run_engine(1000, -1, 10'($urandom), 4'($urandom));
      do_reload();

      // Early ld_last on beat 10, then a missing ld_last on beat 63
      load_table(1, 10, 64);
      wait_release();
      run_engine(30, -1, 10'($urandom), 4'($urandom));
      do_reload();
      load_table(1, 63, 64);
      wait_release();
      run_engine(30, -1, 10'($urandom), 4'($urandom));
      do_reload();

      // Reset in the middle of a load
      load_table(1, -1, 40);
      #2;
      RST = 1'b1;
      #1;
      chk_reset_outputs("midload_rst");
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;
      step();
      RST = 1'b0;
      step();
      load_table(1, -1, 64);
      wait_release();
      run_engine(40, -1, 10'($urandom), 4'($urandom));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
